// File: rtl/alu_sequencer.sv
// Sequences requests from two round-robin requesters onto a shared ALU.
// The sequencer holds the ALU operands for an opcode-dependent latency and returns the result with the requester ID.
module alu_sequencer #(
  parameter int unsigned BASIC_LAT  = 2,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clk_i,
  input  logic        clear_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [5:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [5:0]  req1_op_i,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [5:0]  alu_sel_o,
  input  logic [31:0] alu_low_i,
  input  logic [31:0] alu_high_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_low_o,
  output logic [31:0] rsp_high_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam logic [5:0] BasicCnt  = 6'(BASIC_LAT - 1);
  localparam logic [5:0] MulDivCnt = 6'(MULDIV_LAT - 1);
  localparam logic [5:0] OpDiv     = 6'd2;
  localparam logic [5:0] OpMul     = 6'd6;
  localparam logic [5:0] OpMax     = 6'd12;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [5:0]  alu_sel_q, alu_sel_d;
  logic        rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_low_q, rsp_low_d, rsp_high_q, rsp_high_d;

  logic        any_req, gnt1, op_illegal;
  logic [31:0] sel_a, sel_b;
  logic [5:0]  sel_op, sel_cnt;

  // On a tie, req1 wins only when req0 was granted last.
  always_comb begin
    any_req    = req0_valid_i | req1_valid_i;
    gnt1       = req1_valid_i & (~req0_valid_i | ~last_grant_q);
    sel_a      = gnt1 ? req1_a_i : req0_a_i;
    sel_b      = gnt1 ? req1_b_i : req0_b_i;
    sel_op     = gnt1 ? req1_op_i : req0_op_i;
    op_illegal = sel_op > OpMax;
    sel_cnt    = (sel_op == OpDiv || sel_op == OpMul) ? MulDivCnt : BasicCnt;
  end

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_low_q    <= '0;
      rsp_high_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_low_q    <= rsp_low_d;
      rsp_high_q   <= rsp_high_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_low_d    = rsp_low_q;
    rsp_high_d   = rsp_high_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          last_grant_d = gnt1;
          rsp_id_d     = gnt1;
          // Illegal opcodes never reach the ALU; they answer with an error at once.
          if (op_illegal) begin
            rsp_err_d  = 1'b1;
            rsp_low_d  = '0;
            rsp_high_d = '0;
            state_d    = StResp;
          end else begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_sel_d = sel_op;
            cnt_d     = sel_cnt;
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          rsp_low_d  = alu_low_i;
          rsp_high_d = alu_high_i;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req0_ready_o = (state_q == StIdle) & req0_valid_i & ~gnt1;
    req1_ready_o = (state_q == StIdle) & gnt1;
    rsp_valid_o  = (state_q == StResp);
    busy_o       = (state_q != StIdle);
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_sel_o  = alu_sel_q;
  assign rsp_id_o   = rsp_id_q;
  assign rsp_err_o  = rsp_err_q;
  assign rsp_low_o  = rsp_low_q;
  assign rsp_high_o = rsp_high_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequences operations onto the shared 32-bit ALU on behalf of two requesters, such as the control unit and a debug/test port. It arbitrates round-robin and drives the operands and select. It holds them stable for an opcode-dependent number of cycles, then captures the low/high result. The result is returned on a valid/ready response channel tagged with the requester ID. It sits between the requesters and the ALU instance, and is the only driver of the ALU's A, B and select inputs.

## Interface
- BASIC_LAT, 2: EXEC cycles for opcodes 0,1,3,4,5,7,8,9,10,11,12 (legal range 1..63)
- MULDIV_LAT, 4: EXEC cycles for opcodes 2 (div) and 6 (mul) (legal range 1..63)
- clk  in  1  single clock; all state changes on rising edge
- clear  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N has an operation pending
- req0_ready / req1_ready  out  1  requester N's operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_op / req1_op  in  6  ALU opcode (0..12 legal)
- alu_a, alu_b  out  32  registered operands to ALU
- alu_sel  out  6  registered opcode to ALU
- alu_low, alu_high  in  32  ALU result (high = mul upper word or div remainder)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester the response belongs to
- rsp_low, rsp_high  out  32  captured result
- rsp_err  out  1  opcode was illegal (>12)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant one; assert that reqN_ready combinationally this cycle, the other ready 0. Latch its a/b/op into alu_a/alu_b/alu_sel, its ID into rsp_id. Load cnt = LAT(op)-1. Go to EXEC.
- Arbitration: if only one is valid, grant it. If both are valid, grant the one not granted last; last_grant is updated on each grant.
- Illegal op (>12) in IDLE: still accepted. alu_a/alu_b/alu_sel are NOT updated. rsp_err=1, rsp_low=rsp_high=0. Go directly to RESP.
- EXEC: alu_* held constant. If cnt==0, capture alu_low→rsp_low, alu_high→rsp_high, rsp_err=0, go to RESP; otherwise cnt-=1.
- RESP: rsp_valid=1; rsp_* held stable. On rsp_valid&rsp_ready go to IDLE (no acceptance in the same cycle).
- reqN_ready is 0 in EXEC and RESP. Requesters must hold valid and payload until ready.
- cnt is 6 bits; LAT values outside 1..63 are a configuration error (not checked).

## Timing
- Reset (clear=0 at rising edge, any state, mid-EXEC included):
  - state=IDLE; outstanding op discarded.
  - alu_a=alu_b=0, alu_sel=0, rsp_valid=0, rsp_low=rsp_high=0, rsp_id=0, rsp_err=0, busy=0, cnt=0.
  - last_grant=1, so req0 wins the first tie.
- Accept at cycle T (reqN_valid & reqN_ready high):
  - alu_* valid from T+1; EXEC occupies T+1..T+L.
  - rsp_valid rises at T+L+1; illegal op: rsp_valid at T+1.
- Response handshake at cycle R: rsp_valid=0 at R+1. Earliest next accept is R+1.
- Minimum period per op is L+2 cycles with rsp_ready tied high.
- busy=1 from T+1 through the handshake cycle R.

## Test plan
- Reset, then req0 ADD (op 0) a=5 b=7 accepted at T, rsp_ready=1 -> alu_sel=0 at T+1; rsp_valid at T+3 with rsp_low=12, rsp_high=0, rsp_id=0, rsp_err=0.
- req1 DIV (op 2) a=100 b=7 -> rsp_valid at T+5; rsp_low=14, rsp_high=2, rsp_id=1.
- Both valid after reset, each ADD 1+1 / 2+2 held -> req0 served first (low=2), req1 next (low=4). Then both valid again -> req0 granted (req1 was last).
- req0 op=13 -> ready at T, rsp_valid at T+1, rsp_err=1, low=high=0; alu_sel unchanged from prior op.
- MUL a=0x10000 b=0x10000 with rsp_ready=0 for 6 cycles -> rsp_high=1, rsp_low=0. rsp_* stable and both reqN_ready=0 while stalled; IDLE one cycle after rsp_ready=1.
- clear=0 for one cycle during EXEC of a DIV -> next cycle: busy=0, rsp_valid=0, alu_*=0. No response is ever produced for the discarded op.
